// File: rtl/calc_op_if.sv
// ---------------------------------------------------------------------------
// calc_op_if
//   Request/result handshake bundle between the calculator FSM (master) and
//   the multi-cycle arithmetic sequencer (slave).
//   Request  : in_valid/in_ready, in_op (0 ADD, 1 SUB, 2 MUL, 3 DIV), in_a, in_b
//   Result   : out_valid/out_ready, out_result, out_err, out_err_code
//   Operands and the result are signed fixed-point values scaled by 1000.
// ---------------------------------------------------------------------------
interface calc_op_if #(
  parameter int W = 25
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_op;
  logic signed [W-1:0] in_a;
  logic signed [W-1:0] in_b;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_result;
  logic                out_err;
  logic [1:0]          out_err_code;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err, out_err_code
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err, out_err_code
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// calc_op_sequencer
//   Multi-cycle fixed-point arithmetic unit for the keypad calculator.
//   One op is accepted in IDLE; ADD/SUB finish in one cycle, MUL runs a
//   shift-add multiplier and then reuses the restoring divider to scale the
//   product down by SCALE, DIV runs the divider on |a|*SCALE / |b|.
//   Magnitudes are computed unsigned and the sign is applied in FIX, so MUL
//   and DIV truncate toward zero. Latency is fixed per op type.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous abort back to IDLE (drops any pending result)
//   bus    : calc_op_if.slave request/result handshake
//   busy   : high in every state except IDLE
// ---------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int W       = 25,
  parameter int SCALE   = 1000,
  parameter int MAX_POS = 9999000,
  parameter int MIN_NEG = -999000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  calc_op_if.slave    bus,
  output logic        busy
);

  localparam int DW = 2 * W;
  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0]    OP_ADD = 2'd0;
  localparam logic [1:0]    OP_SUB = 2'd1;
  localparam logic [1:0]    OP_MUL = 2'd2;
  localparam logic [1:0]    OP_DIV = 2'd3;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DW);
  localparam logic [DW-1:0] SCALE_DW = DW'(SCALE);
  localparam logic [W:0]    SCALE_DV = (W + 1)'(SCALE);
  localparam logic [DW-1:0] POS_LIM  = DW'(MAX_POS);
  localparam logic [DW-1:0] NEG_LIM  = DW'(-MIN_NEG);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_DIV    = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Two's complement magnitude; -2^(W-1) maps to 2^(W-1) as an unsigned value.
  function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
    if (v[W-1]) begin
      mag_of = (~v) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      mag_of = v;
    end
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [DW-1:0] mcand_q, mcand_d;   // |a|, shifted left during MUL
  logic [W-1:0]  mplr_q, mplr_d;     // |b|, shifted right during MUL; divisor for DIV
  logic [DW-1:0] dq_q, dq_d;         // product, then dividend shifting out / quotient shifting in
  logic [W-1:0]  rem_q, rem_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_result_q, out_result_d;
  logic          out_err_q, out_err_d;
  logic [1:0]    out_code_q, out_code_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic [W:0]    a_ext_s, b_ext_s, sum_s, sum_mag_s;
  logic [W:0]    rem_sh_s, divisor_s, diff_s;
  logic          ge_s;
  logic [DW-1:0] neg_full_s;
  logic [W-1:0]  res_s;
  logic          ovf_s;

  // Datapath helpers: add/sub, one restoring-divide step, sign/range fix-up.
  always_comb begin
    a_ext_s = {a_q[W-1], a_q};
    b_ext_s = {b_q[W-1], b_q};
    if (op_q == OP_SUB) begin
      sum_s = a_ext_s - b_ext_s;
    end else begin
      sum_s = a_ext_s + b_ext_s;
    end
    if (sum_s[W]) begin
      sum_mag_s = (~sum_s) + {{W{1'b0}}, 1'b1};
    end else begin
      sum_mag_s = sum_s;
    end

    // MUL always divides by SCALE; DIV divides by |b| which MUL never shifted.
    if (op_q == OP_MUL) begin
      divisor_s = SCALE_DV;
    end else begin
      divisor_s = {1'b0, mplr_q};
    end
    rem_sh_s = {rem_q, dq_q[DW-1]};
    diff_s   = rem_sh_s - divisor_s;
    ge_s     = (rem_sh_s >= divisor_s);

    // Range check on the full-width magnitude before truncating to W bits.
    neg_full_s = (~dq_q) + {{(DW-1){1'b0}}, 1'b1};
    if (neg_q) begin
      ovf_s = (dq_q > NEG_LIM);
      res_s = neg_full_s[W-1:0];
    end else begin
      ovf_s = (dq_q > POS_LIM);
      res_s = dq_q[W-1:0];
    end
  end

  // Next-state and next-output logic; clear overrides everything except outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    neg_d        = neg_q;
    dz_d         = dz_q;
    a_d          = a_q;
    b_d          = b_q;
    mcand_d      = mcand_q;
    mplr_d       = mplr_q;
    dq_d         = dq_q;
    rem_d        = rem_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    out_code_d   = out_code_q;

    if (clear) begin
      state_d     = S_IDLE;
      cnt_d       = CNT_ZERO;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            op_d    = bus.in_op;
            mcand_d = {{W{1'b0}}, mag_of(bus.in_a)};
            mplr_d  = mag_of(bus.in_b);
            neg_d   = bus.in_a[W-1] ^ bus.in_b[W-1];
            dz_d    = (bus.in_op == OP_DIV) && (bus.in_b == {W{1'b0}});
            dq_d    = {DW{1'b0}};
            rem_d   = {W{1'b0}};
            cnt_d   = CNT_ZERO;
            case (bus.in_op)
              OP_ADD, OP_SUB: state_d = S_ADDSUB;
              OP_MUL:         state_d = S_MUL;
              OP_DIV: begin
                if (bus.in_b == {W{1'b0}}) begin
                  state_d = S_FIX;
                end else begin
                  state_d = S_DIV;
                end
              end
              default:        state_d = S_IDLE;
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ADDSUB: begin
          // Store sign + magnitude so FIX treats every op the same way.
          neg_d   = sum_s[W];
          dq_d    = {{(DW-W-1){1'b0}}, sum_mag_s};
          state_d = S_FIX;
        end

        S_MUL: begin
          if (mplr_q[0]) begin
            dq_d = dq_q + mcand_q;
          end else begin
            dq_d = dq_q;
          end
          mcand_d = {mcand_q[DW-2:0], 1'b0};
          mplr_d  = {1'b0, mplr_q[W-1:1]};
          if (cnt_q == MUL_LAST) begin
            cnt_d   = CNT_ZERO;
            state_d = S_DIV;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end

        S_DIV: begin
          if (cnt_q == CNT_ZERO) begin
            // Load cycle: MUL leaves its product in dq; DIV needs |a|*SCALE.
            if (op_q == OP_DIV) begin
              dq_d = mcand_q * SCALE_DW;
            end else begin
              dq_d = dq_q;
            end
            rem_d = {W{1'b0}};
            cnt_d = CNT_ONE;
          end else begin
            rem_d = ge_s ? diff_s[W-1:0] : rem_sh_s[W-1:0];
            dq_d  = {dq_q[DW-2:0], ge_s};
            if (cnt_q == DIV_LAST) begin
              cnt_d   = CNT_ZERO;
              state_d = S_FIX;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
        end

        S_FIX: begin
          // Divide-by-zero waits one extra cycle so its latency equals ADD/SUB.
          if (dz_q && (cnt_q == CNT_ZERO)) begin
            cnt_d = CNT_ONE;
          end else begin
            cnt_d       = CNT_ZERO;
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            if (dz_q) begin
              out_result_d = {W{1'b0}};
              out_err_d    = 1'b1;
              out_code_d   = 2'd2;
            end else if (ovf_s) begin
              out_result_d = {W{1'b0}};
              out_err_d    = 1'b1;
              out_code_d   = 2'd1;
            end else begin
              out_result_d = res_s;
              out_err_d    = 1'b0;
              out_code_d   = 2'd0;
            end
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end
        end

        default: begin
          state_d     = S_IDLE;
          cnt_d       = CNT_ZERO;
          out_valid_d = 1'b0;
        end
      endcase
    end

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      op_q         <= OP_ADD;
      neg_q        <= 1'b0;
      dz_q         <= 1'b0;
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      mcand_q      <= {DW{1'b0}};
      mplr_q       <= {W{1'b0}};
      dq_q         <= {DW{1'b0}};
      rem_q        <= {W{1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= {W{1'b0}};
      out_err_q    <= 1'b0;
      out_code_q   <= 2'd0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      dz_q         <= dz_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mcand_q      <= mcand_d;
      mplr_q       <= mplr_d;
      dq_q         <= dq_d;
      rem_q        <= rem_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      out_code_q   <= out_code_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_err      = out_err_q;
  assign bus.out_err_code = out_code_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_op_sequencer
//   Directed bench for calc_op_sequencer. A cycle model computes each result
//   with plain integer arithmetic and the documented per-op latency; a
//   compare process checks every DUT output against it on each falling edge.
//   Directed calls also pin latency and result to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_calc_op_sequencer;

  localparam int W       = 25;
  localparam int SCALE   = 1000;
  localparam int MAX_POS = 9999000;
  localparam int MIN_NEG = -999000;

  logic clk;
  logic rst_n;
  logic clear;
  logic busy;

  calc_op_if #(.W(W)) bus ();

  calc_op_sequencer #(
    .W(W), .SCALE(SCALE), .MAX_POS(MAX_POS), .MIN_NEG(MIN_NEG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    longint      res;
    logic        err;
    logic [1:0]  code;
    int          lat;
  } exp_t;

  // Result of one op straight from the arithmetic rules.
  function automatic exp_t model_op(input logic [1:0] op, input logic signed [W-1:0] a,
                                    input logic signed [W-1:0] b);
    exp_t   e;
    longint la, lb, ma, mb, v;
    bit     neg, dz;
    la  = a;
    lb  = b;
    ma  = (la < 0) ? -la : la;
    mb  = (lb < 0) ? -lb : lb;
    neg = (la < 0) != (lb < 0);
    dz  = 1'b0;
    v   = 0;
    case (op)
      2'd0: begin v = la + lb; e.lat = 2; end
      2'd1: begin v = la - lb; e.lat = 2; end
      2'd2: begin v = (ma * mb) / SCALE; if (neg) v = -v; e.lat = 3 * W + 2; end
      default: begin
        if (lb == 0) begin
          dz = 1'b1; e.lat = 2;
        end else begin
          v = (ma * SCALE) / mb; if (neg) v = -v; e.lat = 2 * W + 2;
        end
      end
    endcase
    if (dz) begin
      e.res = 0; e.err = 1'b1; e.code = 2'd2;
    end else if (v > MAX_POS || v < MIN_NEG) begin
      e.res = 0; e.err = 1'b1; e.code = 2'd1;
    end else begin
      e.res = v; e.err = 1'b0; e.code = 2'd0;
    end
    return e;
  endfunction

  // Model state: what the outputs must be after each rising edge.
  logic   m_busy, m_valid, m_err;
  logic [1:0] m_code;
  longint m_res;
  int     m_age;
  exp_t   p;

  // Cycle model of the handshake and fixed latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_res   <= 0;
      m_err   <= 1'b0;
      m_code  <= 2'd0;
      m_age   <= 0;
    end else if (clear) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (m_age + 1 == p.lat) begin
        m_valid <= 1'b1;
        m_res   <= p.res;
        m_err   <= p.err;
        m_code  <= p.code;
      end
    end else if (bus.in_valid) begin
      p      <= model_op(bus.in_op, bus.in_a, bus.in_b);
      m_age  <= 0;
      m_busy <= 1'b1;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    check("in_ready", bus.in_ready, !m_busy);
    check("busy", busy, m_busy);
    check("out_valid", bus.out_valid, m_valid);
    check("out_result", bus.out_result, m_res);
    check("out_err", bus.out_err, m_err);
    check("out_err_code", bus.out_err_code, m_code);
  end

  // Issue one op at a falling edge, wait for the result, check literals.
  task automatic run_op(input string nm, input logic [1:0] op, input int a, input int b,
                        input int exp_res, input int exp_err, input int exp_code,
                        input int exp_lat, input int hold);
    int k;
    bus.in_op     = op;
    bus.in_a      = W'(a);
    bus.in_b      = W'(b);
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, k, exp_lat);
    check({nm, " result"}, bus.out_result, exp_res);
    check({nm, " err"}, bus.out_err, exp_err);
    check({nm, " code"}, bus.out_err_code, exp_code);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = i[0];
        bus.in_op    = 2'd0;
        bus.in_a     = W'(77);
        bus.in_b     = W'(11);
        @(negedge clk);
        check({nm, " hold in_ready"}, bus.in_ready, 0);
        check({nm, " hold out_valid"}, bus.out_valid, 1);
        check({nm, " hold result"}, bus.out_result, exp_res);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({nm, " in_ready after transfer"}, bus.in_ready, 1);
    check({nm, " out_valid after transfer"}, bus.out_valid, 0);
  endtask

  // Directed stimulus.
  initial begin
    bit seen;
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset in_ready", bus.in_ready, 1);
    check("reset busy", busy, 0);
    check("reset result", bus.out_result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("T1 add",       2'd0,    1500,    2250,  3750, 0, 0,  2, 0);
    run_op("T2 mul",       2'd2,    2500,   -1500, -3750, 0, 0, 77, 0);
    run_op("T2 mul tiny",  2'd2,      -1,       1,     0, 0, 0, 77, 0);
    run_op("T3 div",       2'd3,    1000,    3000,   333, 0, 0, 52, 0);
    run_op("T3 div neg",   2'd3,   -7000,    2000, -3500, 0, 0, 52, 0);
    run_op("T4 div0",      2'd3,    5000,       0,     0, 1, 2,  2, 0);
    run_op("T4 add ovf",   2'd0, 9999000,    1000,     0, 1, 1,  2, 0);
    run_op("T4 sub ovf",   2'd1, -999000,    1000,     0, 1, 1,  2, 0);
    run_op("T4 add max",   2'd0, 9999000,       0, 9999000, 0, 0, 2, 0);
    run_op("sub min",      2'd1, -999000,       0, -999000, 0, 0, 2, 0);
    run_op("mul wide ovf", 2'd2, 9999000, 9999000,     0, 1, 1, 77, 0);
    run_op("T5 hold",      2'd1,     500,    2000, -1500, 0, 0,  2, 10);

    // T6a: clear 30 cycles into a MUL.
    bus.in_op    = 2'd2;
    bus.in_a     = W'(2500);
    bus.in_b     = W'(2000);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("T6 clear busy", busy, 0);
    check("T6 clear in_ready", bus.in_ready, 1);
    check("T6 clear keeps result", bus.out_result, -1500);
    seen = 1'b0;
    repeat (90) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("T6 no result after clear", seen, 0);

    // Accept attempted in the same cycle as clear is dropped.
    bus.in_op    = 2'd0;
    bus.in_a     = W'(1);
    bus.in_b     = W'(2);
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear        = 1'b0;
    check("T6 clear+accept busy", busy, 0);
    repeat (4) @(negedge clk);

    // T6b: async reset in the middle of a DIV, then a clean DIV.
    bus.in_op    = 2'd3;
    bus.in_a     = W'(9000);
    bus.in_b     = W'(4000);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("T6 reset busy", busy, 0);
    check("T6 reset in_ready", bus.in_ready, 1);
    check("T6 reset result", bus.out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("T6 div after reset", 2'd3, 9000, 4000, 2250, 0, 0, 52, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
